npc_redirect: RTL and testbench

- Next-PC and redirect controller at the consumer end of the EX-stage branch resolver's npc_sel output.
- Owns the IF-stage PC register and computes branch/jump targets.
- Generates IF/ID and ID/EX flushes when a redirect is accepted.
- Buffers a redirect that arrives while fetch is stalled; keeps branch performance counters.

---
 rtl/npc_redirect_if.sv | 37 +++
 rtl/npc_redirect.sv | 90 +++++++++
 tb/tb_npc_redirect.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/npc_redirect_if.sv
// Next-PC redirect bus: EX-stage branch resolution in, fetch PC/flush/counters out.
// master = pipeline side (drives EX inputs), slave = npc_redirect.
interface npc_redirect_if #(
    parameter int CNT_W = 32
);
    logic             stall_if;
    logic             stall_ex;
    logic             valid_ex;
    logic             is_br_ex;
    logic [1:0]       npc_sel_ex;
    logic [31:0]      pc_ex;
    logic [31:0]      offs_ex;
    logic [31:0]      rj_ex;
    logic [31:0]      pc_if;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             redirect_pending;
    logic             target_misalign;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] br_taken_cnt;

    modport master (
        output stall_if, stall_ex, valid_ex, is_br_ex,
        output npc_sel_ex, pc_ex, offs_ex, rj_ex,
        input  pc_if, flush_if_id, flush_id_ex,
        input  redirect_pending, target_misalign,
        input  br_cnt, br_taken_cnt
    );

    modport slave (
        input  stall_if, stall_ex, valid_ex, is_br_ex,
        input  npc_sel_ex, pc_ex, offs_ex, rj_ex,
        output pc_if, flush_if_id, flush_id_ex,
        output redirect_pending, target_misalign,
        output br_cnt, br_taken_cnt
    );
endinterface

// File: rtl/npc_redirect.sv
// Next-PC / redirect controller: owns the fetch PC, applies EX redirects,
// buffers a redirect while fetch stalls, and counts resolved/taken branches.
// Ports: clk, rstn (sync, active-low), bus (npc_redirect_if.slave).
module npc_redirect #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000,
    parameter int          CNT_W    = 32
) (
    input  logic           clk,
    input  logic           rstn,
    npc_redirect_if.slave  bus
);
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pend_q, pend_d;
    logic             mis_q, mis_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] tk_cnt_q, tk_cnt_d;

    logic        accept;
    logic        take;
    logic [31:0] raw_tgt;
    logic [31:0] tgt;

    assign accept  = bus.valid_ex & ~bus.stall_ex & bus.is_br_ex;
    assign take    = accept & bus.npc_sel_ex[1];
    // sel[0] picks pc-relative (11) over register-relative jirl (10)
    assign raw_tgt = (bus.npc_sel_ex[0] ? bus.pc_ex : bus.rj_ex)
                   + bus.offs_ex;
    assign tgt     = {raw_tgt[31:2], 2'b00};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pend_d   = pend_q;
        mis_d    = take & (raw_tgt[1:0] != 2'b00);
        br_cnt_d = br_cnt_q + {{(CNT_W-1){1'b0}}, accept};
        tk_cnt_d = tk_cnt_q + {{(CNT_W-1){1'b0}}, take};
        if (state_q == RUN) begin
            if (take) begin
                if (bus.stall_if) begin
                    pend_d  = tgt;
                    state_d = HOLD;
                end else begin
                    pc_d = tgt;
                end
            end else if (!bus.stall_if) begin
                pc_d = pc_q + 32'd4;
            end
        end else begin
            // youngest redirect wins over the buffered one
            if (take) begin
                pend_d = tgt;
            end
            if (!bus.stall_if) begin
                pc_d    = take ? tgt : pend_q;
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            pend_q   <= 32'h0;
            mis_q    <= 1'b0;
            br_cnt_q <= '0;
            tk_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pend_q   <= pend_d;
            mis_q    <= mis_d;
            br_cnt_q <= br_cnt_d;
            tk_cnt_q <= tk_cnt_d;
        end
    end

    assign bus.pc_if            = pc_q;
    assign bus.flush_id_ex      = take;
    // while holding, whatever fetch returns is wrong-path
    assign bus.flush_if_id      = take | (state_q == HOLD);
    assign bus.redirect_pending = (state_q == HOLD);
    assign bus.target_misalign  = mis_q;
    assign bus.br_cnt           = br_cnt_q;
    assign bus.br_taken_cnt     = tk_cnt_q;
endmodule

// File: tb/tb_npc_redirect.sv
// Scoreboard bench for npc_redirect: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares.
module tb_npc_redirect;
    logic clk = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    npc_redirect_if #(.CNT_W(32)) bus ();

    npc_redirect #(
        .RESET_PC (32'h1c00_0000),
        .CNT_W    (32)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [31:0] pc;
        logic        fi;
        logic        fe;
        logic        rp;
        logic        mis;
        logic [31:0] bc;
        logic [31:0] tc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_if", bus.pc_if, e.pc);
                chk("flush_if_id", 32'(bus.flush_if_id), 32'(e.fi));
                chk("flush_id_ex", 32'(bus.flush_id_ex), 32'(e.fe));
                chk("redirect_pending", 32'(bus.redirect_pending), 32'(e.rp));
                chk("target_misalign", 32'(bus.target_misalign), 32'(e.mis));
                chk("br_cnt", bus.br_cnt, e.bc);
                chk("br_taken_cnt", bus.br_taken_cnt, e.tc);
                cyc++;
            end
        end
    end

    // drive one cycle of inputs and queue the outputs expected this cycle
    task automatic step(
        input logic rst, input logic sif, input logic sex,
        input logic v, input logic br, input logic [1:0] sel,
        input logic [31:0] pce, input logic [31:0] off,
        input logic [31:0] rj,
        input logic [31:0] e_pc, input logic e_fi, input logic e_fe,
        input logic e_rp, input logic e_mis,
        input logic [31:0] e_bc, input logic [31:0] e_tc);
        exp_t e;
        rstn           = rst;
        bus.stall_if   = sif;
        bus.stall_ex   = sex;
        bus.valid_ex   = v;
        bus.is_br_ex   = br;
        bus.npc_sel_ex = sel;
        bus.pc_ex      = pce;
        bus.offs_ex    = off;
        bus.rj_ex      = rj;
        e.pc = e_pc; e.fi = e_fi; e.fe = e_fe; e.rp = e_rp;
        e.mis = e_mis; e.bc = e_bc; e.tc = e_tc;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic sif, input logic [31:0] e_pc,
                        input logic e_fi, input logic e_rp,
                        input logic e_mis,
                        input logic [31:0] e_bc, input logic [31:0] e_tc);
        step(1, sif, 0, 0, 0, 2'b00, 0, 0, 0,
             e_pc, e_fi, 0, e_rp, e_mis, e_bc, e_tc);
    endtask

    initial begin : driver
        int wait_cyc;
        bus.stall_if = 0; bus.stall_ex = 0; bus.valid_ex = 0;
        bus.is_br_ex = 0; bus.npc_sel_ex = 0; bus.pc_ex = 0;
        bus.offs_ex = 0; bus.rj_ex = 0;
        rstn = 0;
        repeat (2) @(posedge clk);
        #1;
        // sequential fetch from reset
        idle(0, 32'h1c00_0000, 0, 0, 0, 0, 0);
        idle(0, 32'h1c00_0004, 0, 0, 0, 0, 0);
        idle(0, 32'h1c00_0008, 0, 0, 0, 0, 0);
        idle(0, 32'h1c00_000C, 0, 0, 0, 0, 0);
        // taken beq
        step(1, 0, 0, 1, 1, 2'b11, 32'h1c00_0100, 32'h40, 0,
             32'h1c00_0010, 1, 1, 0, 0, 0, 0);
        idle(0, 32'h1c00_0140, 0, 0, 0, 1, 1);
        // misaligned jirl
        step(1, 0, 0, 1, 1, 2'b10, 0, 32'h4, 32'h1c00_2003,
             32'h1c00_0144, 1, 1, 0, 0, 1, 1);
        idle(0, 32'h1c00_2004, 0, 0, 1, 2, 2);
        idle(0, 32'h1c00_2008, 0, 0, 0, 2, 2);
        // take during fetch stall, held 3 cycles
        step(1, 1, 0, 1, 1, 2'b11, 32'h1c00_0100, 32'h100, 0,
             32'h1c00_200C, 1, 1, 0, 0, 2, 2);
        idle(1, 32'h1c00_200C, 1, 1, 0, 3, 3);
        idle(1, 32'h1c00_200C, 1, 1, 0, 3, 3);
        idle(1, 32'h1c00_200C, 1, 1, 0, 3, 3);
        idle(0, 32'h1c00_200C, 1, 1, 0, 3, 3);
        idle(0, 32'h1c00_0200, 0, 0, 0, 3, 3);
        // not-taken and reserved selects
        step(1, 0, 0, 1, 1, 2'b00, 32'h1c00_0100, 32'h40, 0,
             32'h1c00_0204, 0, 0, 0, 0, 3, 3);
        step(1, 0, 0, 1, 1, 2'b01, 32'h1c00_0100, 32'h40, 0,
             32'h1c00_0208, 0, 0, 0, 0, 4, 3);
        // stall_ex ignores EX entirely
        step(1, 0, 1, 1, 1, 2'b11, 32'h1c00_0100, 32'h40, 0,
             32'h1c00_020C, 0, 0, 0, 0, 5, 3);
        step(1, 1, 1, 1, 1, 2'b11, 32'h1c00_0100, 32'h40, 0,
             32'h1c00_0210, 0, 0, 0, 0, 5, 3);
        idle(0, 32'h1c00_0210, 0, 0, 0, 5, 3);
        // HOLD: youngest take overwrites pending target
        step(1, 1, 0, 1, 1, 2'b11, 32'h1c00_0000, 32'h400, 0,
             32'h1c00_0214, 1, 1, 0, 0, 5, 3);
        step(1, 1, 0, 1, 1, 2'b11, 32'h1c00_0000, 32'h500, 0,
             32'h1c00_0214, 1, 1, 1, 0, 6, 4);
        idle(0, 32'h1c00_0214, 1, 1, 0, 7, 5);
        idle(0, 32'h1c00_0500, 0, 0, 0, 7, 5);
        // HOLD: take with fetch free applies new target, not pend
        step(1, 1, 0, 1, 1, 2'b11, 32'h1c00_0000, 32'h600, 0,
             32'h1c00_0504, 1, 1, 0, 0, 7, 5);
        step(1, 0, 0, 1, 1, 2'b11, 32'h1c00_0000, 32'h700, 0,
             32'h1c00_0504, 1, 1, 1, 0, 8, 6);
        idle(0, 32'h1c00_0700, 0, 0, 0, 9, 7);
        // reset while holding a pending redirect
        step(1, 1, 0, 1, 1, 2'b11, 32'h1c00_0000, 32'h300, 0,
             32'h1c00_0704, 1, 1, 0, 0, 9, 7);
        idle(1, 32'h1c00_0704, 1, 1, 0, 10, 8);
        step(0, 1, 0, 0, 0, 2'b00, 0, 0, 0,
             32'h1c00_0704, 1, 0, 1, 0, 10, 8);
        idle(0, 32'h1c00_0000, 0, 0, 0, 0, 0);
        idle(0, 32'h1c00_0004, 0, 0, 0, 0, 0);
        // pc+4 wrap and target add wrap
        step(1, 0, 0, 1, 1, 2'b11, 32'h0, 32'hFFFF_FFFC, 0,
             32'h1c00_0008, 1, 1, 0, 0, 0, 0);
        idle(0, 32'hFFFF_FFFC, 0, 0, 0, 1, 1);
        idle(0, 32'h0000_0000, 0, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1, 2'b11, 32'hFFFF_FFF0, 32'h20, 0,
             32'h0000_0004, 1, 1, 0, 0, 1, 1);
        idle(0, 32'h0000_0010, 0, 0, 0, 2, 2);
        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain left=%0d", q.size());
        end
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
